// File: rtl/dac_sample_feeder_if.sv
// DAC-side handshake bundle between the sample feeder and the PMOD DAC SPI block.
interface dac_sample_feeder_if #(
  parameter int unsigned RESOLUTION = 16
);
  logic [RESOLUTION-1:0] dac_din;
  logic                  dac_load;
  logic                  dac_start;
  logic                  dac_busy;

  modport master (output dac_din, output dac_load, output dac_start, input dac_busy);
  modport slave  (input dac_din, input dac_load, input dac_start, output dac_busy);
endinterface

// File: rtl/dac_sample_feeder.sv
// Buffers SoC samples in a FIFO and releases one per programmable period to the DAC,
// sequencing load/start strobes and tracking the DAC busy handshake.
module dac_sample_feeder #(
  parameter int unsigned RESOLUTION = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RESOLUTION-1:0]         wr_data,
  input  logic                          wr_en,
  input  logic                          flush,
  input  logic                          enable,
  input  logic [DIV_WIDTH-1:0]          rate_div,
  input  logic                          err_clr,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          underrun,
  output logic                          missed_tick,
  output logic                          start_lost,
  dac_sample_feeder_if.master           dac
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned LW        = AW + 1;
  localparam int unsigned WDOG_W    = 3;
  localparam int unsigned WDOG_LAST = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t                state, state_nx;
  logic [RESOLUTION-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level_nx;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [WDOG_W-1:0]     wdog;
  logic                  busy_meta, busy_sync;
  logic                  tick_c, push_c, pop_c;
  logic                  load_nx, start_nx, wdog_clr_c;
  logic                  set_underrun_c, set_lost_c, set_missed_c, set_overflow_c;

  // Full is judged on the registered count, so a same-cycle pop never makes room.
  assign push_c         = wr_en && !full && !flush;
  assign set_overflow_c = wr_en && full && !flush;
  assign level_nx       = level + LW'(push_c) - LW'(pop_c);

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nx;
      full  <= (level_nx == LW'(FIFO_DEPTH));
      empty <= (level_nx == LW'(0));
    end
  end

  // Sample-period timer; a rate_div below the count wraps through the full range.
  assign tick_c = enable && (cnt == rate_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (tick_c)  cnt <= '0;
    else              cnt <= cnt + DIV_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      busy_meta <= dac.dac_busy;
      busy_sync <= busy_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    pop_c          = 1'b0;
    load_nx        = 1'b0;
    start_nx       = 1'b0;
    wdog_clr_c     = 1'b0;
    set_underrun_c = 1'b0;
    set_lost_c     = 1'b0;
    case (state)
      IDLE: begin
        if (tick_c) begin
          if (!empty && !flush) begin
            pop_c    = 1'b1;
            load_nx  = 1'b1;
            state_nx = LOAD;
          end else if (empty) begin
            set_underrun_c = 1'b1;
          end
        end
      end
      LOAD: begin
        start_nx = 1'b1;
        state_nx = START;
      end
      START: begin
        wdog_clr_c = 1'b1;
        state_nx   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy_sync) begin
          state_nx = WAIT_DONE;
        end else if (wdog == WDOG_W'(WDOG_LAST)) begin
          set_lost_c = 1'b1;
          state_nx   = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy_sync) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign set_missed_c = tick_c && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     wdog <= '0;
    else if (wdog_clr_c)         wdog <= '0;
    else if (state == WAIT_BUSY) wdog <= wdog + WDOG_W'(1);
  end

  // Data is captured at pop and held through load and start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dac.dac_din   <= '0;
      dac.dac_load  <= 1'b0;
      dac.dac_start <= 1'b0;
    end else begin
      if (pop_c) dac.dac_din <= mem[rd_ptr];
      dac.dac_load  <= load_nx;
      dac.dac_start <= start_nx;
    end
  end

  // Sticky flags: a same-cycle set beats err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow    <= 1'b0;
      underrun    <= 1'b0;
      missed_tick <= 1'b0;
      start_lost  <= 1'b0;
    end else begin
      overflow    <= set_overflow_c | (overflow    & ~err_clr);
      underrun    <= set_underrun_c | (underrun    & ~err_clr);
      missed_tick <= set_missed_c   | (missed_tick & ~err_clr);
      start_lost  <= set_lost_c     | (start_lost  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder: expected releases are queued by the stimulus
// thread and a monitor checks each load strobe for data, cycle and the following start.
module tb_dac_sample_feeder;

  localparam int unsigned RES   = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [RES-1:0]        wr_data;
  logic                  wr_en, flush, enable, err_clr;
  logic [DW-1:0]         rate_div;
  logic                  full, empty;
  logic [$clog2(DEPTH):0] level;
  logic                  overflow, underrun, missed_tick, start_lost;

  dac_sample_feeder_if #(.RESOLUTION(RES)) dif ();

  dac_sample_feeder #(.RESOLUTION(RES), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .flush      (flush),
    .enable     (enable),
    .rate_div   (rate_div),
    .err_clr    (err_clr),
    .full       (full),
    .empty      (empty),
    .level      (level),
    .overflow   (overflow),
    .underrun   (underrun),
    .missed_tick(missed_tick),
    .start_lost (start_lost),
    .dac        (dif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DAC model: busy for busy_len cycles after each start unless never_busy.
  int busy_len = 20;
  bit never_busy = 1'b0;
  int bcnt;
  always @(posedge clk or posedge rst) begin
    if (rst)                                bcnt <= 0;
    else if (dif.dac_start && !never_busy)  bcnt <= busy_len;
    else if (bcnt > 0)                      bcnt <= bcnt - 1;
  end
  assign dif.dac_busy = (bcnt != 0);

  typedef struct {
    logic [RES-1:0] data;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   loads_seen = 0;
  int   k, ls;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic expect_load(input logic [RES-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [RES-1:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  function automatic logic [3:0] flags();
    return {overflow, underrun, missed_tick, start_lost};
  endfunction

  task automatic monitor();
    logic prev_load;
    exp_t e;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_load || dif.dac_start)
        check("start_follows_load", {31'd0, dif.dac_start && prev_load}, 32'd1);
      if (dif.dac_load) begin
        loads_seen++;
        check("load_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("load_din", 32'(dif.dac_din), 32'(e.data));
          check("load_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_load = dif.dac_load;
    end
  endtask

  initial begin
    rst = 1'b1; wr_data = '0; wr_en = 1'b0; flush = 1'b0; enable = 1'b0;
    err_clr = 1'b0; rate_div = '0;
    fork
      monitor();
    join_none
    step(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_din", 32'(dif.dac_din), 32'h0);
    check("rst_strobes", {30'd0, dif.dac_load, dif.dac_start}, 32'd0);
    check("rst_full_empty", {30'd0, full, empty}, 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", 32'(flags()), 32'd0);

    // Basic release, period 100
    step(1);
    write(16'h1234);
    check("level_after_write", 32'(level), 32'd1);
    write(16'hABCD);
    rate_div = 16'd99; enable = 1'b1; k = cyc;
    expect_load(16'h1234, k + 100);
    expect_load(16'hABCD, k + 200);
    sample(k + 202);
    check("basic_empty", {31'd0, empty}, 32'd1);
    check("basic_flags", 32'(flags()), 32'd0);
    goto(k + 230);
    enable = 1'b0;

    // Overflow
    step(2);
    for (int i = 0; i < 8; i++) write(RES'(16'h1000 + i));
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_level8", 32'(level), 32'd8);
    check("ovf_flag_pre", {31'd0, overflow}, 32'd0);
    write(16'hDEAD);
    check("ovf_level_held", 32'(level), 32'd8);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    pulse_err_clr();
    check("ovf_cleared", {31'd0, overflow}, 32'd0);
    // Drain: contents must be exactly the first eight writes
    busy_len = 5; rate_div = 16'd19; enable = 1'b1; k = cyc;
    for (int i = 0; i < 8; i++) expect_load(RES'(16'h1000 + i), k + 20 * (i + 1));
    goto(k + 165);
    enable = 1'b0;
    check("drain_empty", {31'd0, empty}, 32'd1);
    check("drain_flags", 32'(flags()), 32'd0);

    // Underrun
    step(2);
    ls = loads_seen;
    rate_div = 16'd9; enable = 1'b1; k = cyc;
    sample(k + 9);
    check("udr_before_tick", {31'd0, underrun}, 32'd0);
    sample(k + 10);
    check("udr_after_tick", {31'd0, underrun}, 32'd1);
    goto(k + 25);
    check("udr_no_loads", 32'(loads_seen - ls), 32'd0);
    check("udr_din_held", 32'(dif.dac_din), 32'h1007);
    enable = 1'b0;
    pulse_err_clr();
    check("udr_cleared", {31'd0, underrun}, 32'd0);

    // Missed tick: period 4, busy 30
    step(2);
    busy_len = 30;
    for (int i = 0; i < 4; i++) write(RES'(16'h2000 + i));
    ls = loads_seen;
    rate_div = 16'd3; enable = 1'b1; k = cyc;
    expect_load(16'h2000, k + 4);
    expect_load(16'h2001, k + 40);
    expect_load(16'h2002, k + 76);
    expect_load(16'h2003, k + 112);
    sample(k + 7);
    check("miss_before", {31'd0, missed_tick}, 32'd0);
    sample(k + 8);
    check("miss_set", {31'd0, missed_tick}, 32'd1);
    goto(k + 120);
    enable = 1'b0;
    goto(k + 160);
    check("miss_consumed", 32'(loads_seen - ls), 32'd4);
    check("miss_empty", {31'd0, empty}, 32'd1);
    check("miss_no_underrun", {31'd0, underrun}, 32'd0);
    pulse_err_clr();
    check("miss_cleared", 32'(flags()), 32'd0);

    // Lost start: DAC never goes busy
    step(2);
    never_busy = 1'b1;
    write(16'h3000);
    write(16'h3001);
    rate_div = 16'd19; enable = 1'b1; k = cyc;
    expect_load(16'h3000, k + 20);
    expect_load(16'h3001, k + 40);
    sample(k + 29);
    check("lost_before", {31'd0, start_lost}, 32'd0);
    sample(k + 30);
    check("lost_set", {31'd0, start_lost}, 32'd1);
    goto(k + 45);
    enable = 1'b0;
    goto(k + 60);
    check("lost_empty", {31'd0, empty}, 32'd1);
    pulse_err_clr();
    check("lost_cleared", {31'd0, start_lost}, 32'd0);
    never_busy = 1'b0;

    // Reset during WAIT_DONE
    step(2);
    busy_len = 30;
    write(16'h4000);
    write(16'h4001);
    rate_div = 16'd3; enable = 1'b1; k = cyc;
    expect_load(16'h4000, k + 4);
    sample(k + 15);
    check("pre_rst_level", 32'(level), 32'd1);
    check("pre_rst_din", 32'(dif.dac_din), 32'h4000);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_din", 32'(dif.dac_din), 32'h0);
    check("mid_rst_strobes", {30'd0, dif.dac_load, dif.dac_start}, 32'd0);
    check("mid_rst_full_empty", {30'd0, full, empty}, 32'd1);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_flags", 32'(flags()), 32'd0);
    enable = 1'b0;
    step(2);
    rst = 1'b0;

    // Flush beats a same-cycle write
    step(1);
    write(16'h5000);
    write(16'h5001);
    check("flush_pre_level", 32'(level), 32'd2);
    flush = 1'b1; wr_en = 1'b1; wr_data = 16'h5002;
    step(1);
    flush = 1'b0; wr_en = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_empty", {31'd0, empty}, 32'd1);
    check("flush_no_overflow", {31'd0, overflow}, 32'd0);

    step(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
